mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the core's load/store path.
- Uses the same start/done/active access handshake as the core's memory controller, so stores reach it like ordinary memory.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on tx.
- The core's load/store path supplies address, func3 mode, store data and write enable.

Parameters:
- BASE_ADDRESS, 32'h0001_0000, base of the 12-byte register window (word aligned).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- DEFAULT_DIVISOR, 16'd433, reset value of DIVISOR; bit time = DIVISOR+1 clocks.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle access request
- address  input  32  byte address of the access
- write_enable  input  1  1 = store, 0 = load
- mode  input  3  RISC-V func3; only the low byte is used for TXDATA writes, otherwise ignored
- write_data  input  32  store data
- read_data  output  32  load result; holds until the next accepted access
- done  output  1  one-cycle completion pulse
- active  output  1  access in progress (core stalls on it)
- illegal_address  output  1  pulses with done on a bad address
- tx  output  1  serial line, idle high

Behaviour:
- Register map (offset from BASE_ADDRESS):
  - +0 TXDATA: write pushes write_data[7:0]; reads as 0.
  - +4 STATUS: bit0 full, bit1 empty, bit2 busy (frame in flight), bit3 overflow (sticky), other bits 0. A write with bit3=1 clears overflow; other bits are read-only.
  - +8 DIVISOR: [15:0] read/write; upper bits read 0.
- Access handshake:
  - start is sampled in cycle N only while active=0 and done=0; otherwise it is ignored.
  - Cycle N+1: active=1; the register op commits at the end of N+1.
  - Cycle N+2: active=0, done=1 for one cycle, read_data valid.
  - Fixed latency 2; back-to-back accesses possible from N+3.
- Illegal address: addr[1:0]!=0, or offset outside 0..8.
  - Same timing; illegal_address=1 with done; read_data=0; no side effects.
- FIFO:
  - Circular buffer, read/write pointers one bit wider than index.
  - Full/empty are computed from state at the start of the commit cycle.
  - Push when full: data dropped, overflow set. A pop in the same cycle does not rescue the push.
  - Push to an empty FIFO: the byte is eligible to pop the following cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty: pop into shifter, latch DIVISOR into the bit-timer reload, bit counter=0, go to START.
  - START: tx=0 for DIVISOR+1 clocks, then go to DATA.
  - DATA: tx=shifter[0], LSB first, DIVISOR+1 clocks per bit; go to STOP after bit 7.
  - STOP: tx=1 for DIVISOR+1 clocks, then go to IDLE. A waiting byte starts next cycle: 1 idle clock between frames.
  - busy=1 in every state except IDLE.
  - A DIVISOR write mid-frame affects only the next frame.
- Reset values (asynchronous, applied immediately, even mid-frame or mid-access):
  - tx=1, done=0, active=0, illegal_address=0, read_data=0.
  - FIFO empty, overflow=0, DIVISOR=DEFAULT_DIVISOR, FSM=IDLE.
  - The in-flight access is abandoned; no done is issued.

Test Plan (bench: DEFAULT_DIVISOR=3, BASE_ADDRESS=32'h0001_0000):
- Store 32'h0000_00A5 to 0x10000, mode 010:
  - done at start+2.
  - tx: 4 clks low, bits 1,0,1,0,0,1,0,1 (4 clks each), 4 clks high.
  - STATUS reads 0x2 after the frame.
- Five stores 0x11..0x15 back-to-back while the first frame is in flight:
  - 0x11 pops immediately, so 0x12..0x15 fill the FIFO and nothing is dropped.
  - A sixth store while full: STATUS=0xD (full|busy|overflow); that byte is never transmitted.
- Write 0x8 to STATUS -> overflow clears, STATUS bit3=0.
- Write DIVISOR=7 mid-frame:
  - Current frame keeps 4-clk bits; the next frame uses 8-clk bits.
  - Reading +8 returns 0x0000_0007.
- Loads from 0x10002 and 0x1000C:
  - illegal_address=1 with done, read_data=0.
  - No FIFO or DIVISOR change.
- Assert rst during DATA bit 3 and during an active access:
  - tx=1 and active=0 in the same cycle.
  - STATUS reads 0x2; DIVISOR reads 3.

Source files
------------

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter on the CPU data bus. Stores
//            to TXDATA are queued in a small circular FIFO and serialised
//            LSB first on tx. The bus side uses the memory controller's
//            start/active/done handshake with a fixed two-cycle latency.
//
// Register window (offset from BASE_ADDRESS):
//   +0 TXDATA  W: push write_data[7:0]              R: 0
//   +4 STATUS  R: {overflow, busy, empty, full}     W: bit3=1 clears overflow
//   +8 DIVISOR R/W [15:0]; bit time = DIVISOR+1 clocks
//
// Ports:
//   clk, rst         system clock / asynchronous active-high reset
//   start            one-cycle access request (sampled while idle only)
//   address          byte address of the access
//   write_enable     1 = store, 0 = load
//   mode             func3 of the access (not needed by this block)
//   write_data       store data
//   read_data        load result, held until the next accepted access
//   done             one-cycle completion pulse
//   active           access in progress
//   illegal_address  pulses with done on a misaligned/out-of-window address
//   tx               serial output, idle high
//
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h0001_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic [2:0]  mode,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        done,
  output logic        active,
  output logic        illegal_address,
  output logic        tx
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  localparam logic [31:0] c_off_txdata  = 32'd0;
  localparam logic [31:0] c_off_status  = 32'd4;
  localparam logic [31:0] c_off_divisor = 32'd8;

  localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Bus handshake registers
  // --------------------------------------------------------------------------
  logic        r_active;
  logic        r_done;
  logic        r_illegal;
  logic [31:0] r_read_data;
  logic [31:0] r_addr;
  logic        r_we;
  logic [15:0] r_wdata;

  logic        w_accept;
  logic [31:0] w_offset;
  logic        w_illegal;
  logic        w_wr_txdata;
  logic        w_wr_status;
  logic        w_wr_divisor;
  logic [31:0] w_rdata;

  // --------------------------------------------------------------------------
  // FIFO, control registers and transmitter state
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic          r_overflow;
  logic [15:0]   r_divisor;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [c_aw-1:0] w_wr_idx;
  logic [c_aw-1:0] w_rd_idx;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [7:0]    r_shift;
  logic [15:0]   r_timer;
  logic [15:0]   r_reload;
  logic [2:0]    r_bit_cnt;
  logic          w_bit_end;
  logic          w_tx;
  logic          w_busy;

  // Inputs with no function in this block; reduced so they stay visibly tied off.
  logic w_unused_ok;
  assign w_unused_ok = ^{mode, write_data[31:16]};

  // A request is only taken when neither the commit cycle nor the done cycle
  // of a previous access is in progress.
  assign w_accept = start & ~r_active & ~r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_read_data <= 32'd0;
      r_addr      <= 32'd0;
      r_we        <= 1'b0;
      r_wdata     <= 16'd0;
    end else begin
      // active is exactly one cycle, so done and illegal follow it directly.
      r_active  <= w_accept;
      r_done    <= r_active;
      r_illegal <= r_active & w_illegal;
      if (w_accept) begin
        r_addr  <= address;
        r_we    <= write_enable;
        r_wdata <= write_data[15:0];
      end
      if (r_active) begin
        r_read_data <= w_rdata;
      end
    end
  end

  assign active          = r_active;
  assign done            = r_done;
  assign illegal_address = r_illegal;
  assign read_data       = r_read_data;

  // --------------------------------------------------------------------------
  // Address decode for the commit cycle. Addresses below the base wrap to a
  // large offset and are therefore rejected by the same range compare.
  // --------------------------------------------------------------------------
  assign w_offset  = r_addr - BASE_ADDRESS;
  assign w_illegal = (r_addr[1:0] != 2'b00) || (w_offset > c_off_divisor);

  assign w_wr_txdata  = r_active & r_we & ~w_illegal & (w_offset == c_off_txdata);
  assign w_wr_status  = r_active & r_we & ~w_illegal & (w_offset == c_off_status);
  assign w_wr_divisor = r_active & r_we & ~w_illegal & (w_offset == c_off_divisor);

  // Read mux; writes and illegal accesses return zero.
  always_comb begin
    w_rdata = 32'd0;
    if (!r_we && !w_illegal) begin
      if (w_offset == c_off_status) begin
        w_rdata = {28'd0, r_overflow, w_busy, w_empty, w_full};
      end else if (w_offset == c_off_divisor) begin
        w_rdata = {16'd0, r_divisor};
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
  // --------------------------------------------------------------------------
  assign w_wr_idx = r_wr_ptr[c_aw-1:0];
  assign w_rd_idx = r_rd_ptr[c_aw-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) && (w_wr_idx == w_rd_idx);

  // Full/empty come from registered pointers, so a pop in the same cycle
  // never makes room for a push, and a freshly pushed byte pops next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_divisor  <= DEFAULT_DIVISOR;
    end else begin
      if (w_wr_txdata) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_wr_status && r_wdata[3]) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_divisor) begin
        r_divisor <= r_wdata[15:0];
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_txdata && !w_full) begin
      r_mem[w_wr_idx] <= r_wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Transmitter FSM
  // --------------------------------------------------------------------------
  assign w_pop     = (r_state == c_st_idle) & ~w_empty;
  assign w_bit_end = (r_timer == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (!w_empty) begin
          w_state_next = c_st_start;
        end
      end
      c_st_start: begin
        if (w_bit_end) begin
          w_state_next = c_st_data;
        end
      end
      c_st_data: begin
        if (w_bit_end && (r_bit_cnt == 3'd7)) begin
          w_state_next = c_st_stop;
        end
      end
      c_st_stop: begin
        if (w_bit_end) begin
          w_state_next = c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_tx   = 1'b1;
    w_busy = 1'b1;
    case (r_state)
      c_st_idle:  w_busy = 1'b0;
      c_st_start: w_tx   = 1'b0;
      c_st_data:  w_tx   = r_shift[0];
      default:    w_tx   = 1'b1;
    endcase
  end

  assign tx = w_tx;

  // Bit timer counts DIVISOR..0, giving DIVISOR+1 clocks per bit. The divisor
  // is copied into r_reload at frame start so a mid-frame DIVISOR write only
  // affects the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= 8'd0;
      r_timer   <= 16'd0;
      r_reload  <= 16'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_pop) begin
      r_shift   <= r_mem[w_rd_idx];
      r_timer   <= r_divisor;
      r_reload  <= r_divisor;
      r_bit_cnt <= 3'd0;
    end else if (r_state != c_st_idle) begin
      if (w_bit_end) begin
        r_timer <= r_reload;
        if (r_state == c_st_data) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end else begin
        r_timer <= r_timer - 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
